program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader.sv | 135 +++++++++++++
 tb/tb_program_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared CPU definitions: loader state encoding and the core's opcode constants.
package program_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CNT_HI  = 4'd1,
        S_CNT_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_WRITE   = 4'd5,
        S_CHECK   = 4'd6,
        S_DONE    = 4'd7,
        S_ERROR   = 4'd8
    } ld_state_e;

    localparam logic [3:0]  OPC_NOP   = 4'h0;
    localparam logic [3:0]  OPC_LOAD  = 4'h1;
    localparam logic [3:0]  OPC_STORE = 4'h2;
    localparam logic [3:0]  OPC_ADD   = 4'h3;
    localparam logic [3:0]  OPC_JUMP  = 4'h4;
    localparam logic [3:0]  OPC_HALT  = 4'hF;
    localparam logic [15:0] NOP_INSTR = {OPC_NOP, 12'h000};

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: count, N (hi,lo) words, 8-bit sum checksum; one memory write per word.
// Latency: write one cycle after a word's lo byte; byte_ready drops in WRITE/IDLE/DONE/ERROR to stall the source.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        en_memory_write,
    output logic [15:0] memory_addr,
    output logic [15:0] data_to_memory,
    output logic        loading,
    output logic        run,
    output logic        error,
    output logic [15:0] words_loaded
);

    ld_state_e   state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] data_q, data_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] words_q, words_d;
    logic [7:0]  csum_q, csum_d;
    logic        run_q, run_d;
    logic        xfer;
    logic [15:0] words_inc;

    assign xfer      = byte_valid && byte_ready;
    assign words_inc = words_q + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            words_q <= '0;
            csum_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            csum_q  <= csum_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        data_d  = data_q;
        addr_d  = addr_q;
        words_d = words_q;
        csum_d  = csum_q;
        run_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_CNT_HI;
                    words_d = '0;
                    csum_d  = '0;
                end
            end
            S_CNT_HI: begin
                if (xfer) begin
                    count_d[15:8] = byte_data;
                    csum_d        = csum_q + byte_data;
                    state_d       = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    count_d[7:0] = byte_data;
                    csum_d       = csum_q + byte_data;
                    state_d      = ({count_q[15:8], byte_data} == 16'd0) ? S_CHECK : S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    csum_d  = csum_q + byte_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                // Address and data are captured here so the write strobe sees only flops.
                if (xfer) begin
                    data_d  = {hi_q, byte_data};
                    addr_d  = BASE_ADDR + words_q;
                    csum_d  = csum_q + byte_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                words_d = words_inc;
                state_d = (words_inc < count_q) ? S_DATA_HI : S_CHECK;
            end
            S_CHECK: begin
                if (xfer) begin
                    if (byte_data == csum_q) begin
                        state_d = S_DONE;
                        run_d   = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign byte_ready      = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                             (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                             (state_q == S_CHECK);
    assign loading         = byte_ready || (state_q == S_WRITE);
    assign en_memory_write = (state_q == S_WRITE);
    assign error           = (state_q == S_ERROR);
    assign run             = run_q;
    assign memory_addr     = addr_q;
    assign data_to_memory  = data_q;
    assign words_loaded    = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench: two loaders (BASE_ADDR 0000 and FFFF) share one byte stream; monitors pop expected writes/run pulses.
module tb_program_loader;

    typedef struct packed {
        logic        is_run;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;

    logic        a_rdy, a_we, a_load, a_run, a_err;
    logic [15:0] a_addr, a_dat, a_words;
    logic        b_rdy, b_we, b_load, b_run, b_err;
    logic [15:0] b_addr, b_dat, b_words;

    int total = 0;
    int bad = 0;
    ev_t qa[$];
    ev_t qb[$];

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(16'h0000)) dut_a (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(a_rdy), .en_memory_write(a_we), .memory_addr(a_addr), .data_to_memory(a_dat),
        .loading(a_load), .run(a_run), .error(a_err), .words_loaded(a_words)
    );

    program_loader #(.BASE_ADDR(16'hFFFF)) dut_b (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(b_rdy), .en_memory_write(b_we), .memory_addr(b_addr), .data_to_memory(b_dat),
        .loading(b_load), .run(b_run), .error(b_err), .words_loaded(b_words)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic ev_t wr(input logic [15:0] addr, input logic [15:0] data);
        ev_t e;
        e.is_run = 1'b0;
        e.addr   = addr;
        e.data   = data;
        return e;
    endfunction

    function automatic ev_t rn();
        ev_t e;
        e = '0;
        e.is_run = 1'b1;
        return e;
    endfunction

    // Monitors: every write strobe or run pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (a_we || a_run) begin
            ev_t e;
            if (qa.size() == 0) begin
                chk("a_unexpected_event", {14'd0, a_run, a_we, a_addr}, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_event_kind", {31'd0, a_run}, {31'd0, e.is_run});
                if (!e.is_run) begin
                    chk("a_write", {a_addr, a_dat}, {e.addr, e.data});
                    chk("a_rdy_in_write", {31'd0, a_rdy}, 32'd0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_we || b_run) begin
            ev_t e;
            if (qb.size() == 0) begin
                chk("b_unexpected_event", {14'd0, b_run, b_we, b_addr}, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_event_kind", {31'd0, b_run}, {31'd0, e.is_run});
                if (!e.is_run) begin
                    chk("b_write", {b_addr, b_dat}, {e.addr, e.data});
                    chk("b_rdy_in_write", {31'd0, b_rdy}, 32'd0);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte until accepted; jitter inserts idle cycles, start_mid holds start high meanwhile.
    task automatic send_byte(input logic [7:0] b, input bit jitter, input bit start_mid);
        int  guard = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk);
            start = start_mid;
            if (jitter && ($urandom_range(0, 2) == 0)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = b;
                done       = a_rdy;
            end
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 32'(guard), 32'd0);
                done = 1;
            end
        end
    endtask

    task automatic send_frame(input bq_t f, input bit jitter, input int start_idx);
        foreach (f[i]) send_byte(f[i], jitter, (i == start_idx));
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic settle_and_drain(input string name);
        repeat (4) @(negedge clk);
        chk({name, "_qa_drained"}, 32'(qa.size()), 32'd0);
        chk({name, "_qb_drained"}, 32'(qb.size()), 32'd0);
    endtask

    initial begin
        bq_t good, badf, zero;
        // Sum of 00 02 12 34 AB CD mod 256 = C0.
        good = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        badf = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F};
        zero = '{8'h00, 8'h00, 8'h00};

        #1;
        chk("rst_outputs_a", {26'd0, a_rdy, a_we, a_load, a_run, a_err, 1'b0}, 32'd0);
        chk("rst_regs_a", {a_addr, a_dat}, 32'd0);
        chk("rst_words_a", {16'd0, a_words}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", {30'd0, a_rdy, a_load}, 32'd0);

        // Good frame
        qa.push_back(wr(16'h0000, 16'h1234)); qa.push_back(wr(16'h0001, 16'hABCD)); qa.push_back(rn());
        qb.push_back(wr(16'hFFFF, 16'h1234)); qb.push_back(wr(16'h0000, 16'hABCD)); qb.push_back(rn());
        pulse_start();
        chk("loading_after_start", {31'd0, a_load}, 32'd1);
        send_frame(good, 0, -1);
        settle_and_drain("good");
        chk("good_words_a", {16'd0, a_words}, 32'd2);
        chk("good_words_b", {16'd0, b_words}, 32'd2);
        chk("good_err_loading", {29'd0, a_err, b_err, a_load}, 32'd0);

        // Bad checksum: writes happen, no run
        qa.push_back(wr(16'h0000, 16'h1234)); qa.push_back(wr(16'h0001, 16'hABCD));
        qb.push_back(wr(16'hFFFF, 16'h1234)); qb.push_back(wr(16'h0000, 16'hABCD));
        pulse_start();
        chk("restart_clears_words", {16'd0, a_words}, 32'd0);
        send_frame(badf, 0, -1);
        settle_and_drain("badck");
        chk("badck_error", {30'd0, a_err, b_err}, 32'd3);
        chk("badck_words_held", {16'd0, a_words}, 32'd2);
        chk("badck_no_ready", {30'd0, a_rdy, a_load}, 32'd0);

        // Empty program
        qa.push_back(rn());
        qb.push_back(rn());
        pulse_start();
        send_frame(zero, 0, -1);
        settle_and_drain("empty");
        chk("empty_words", {16'd0, a_words}, 32'd0);
        chk("empty_error", {31'd0, a_err}, 32'd0);

        // Stalling source with a start pulse inside the frame
        qa.push_back(wr(16'h0000, 16'h1234)); qa.push_back(wr(16'h0001, 16'hABCD)); qa.push_back(rn());
        qb.push_back(wr(16'hFFFF, 16'h1234)); qb.push_back(wr(16'h0000, 16'hABCD)); qb.push_back(rn());
        pulse_start();
        send_frame(good, 1, 3);
        settle_and_drain("jitter");
        chk("jitter_words", {16'd0, a_words}, 32'd2);
        chk("jitter_error", {31'd0, a_err}, 32'd0);

        // Reset after the first word is written
        qa.push_back(wr(16'h0000, 16'h1234));
        qb.push_back(wr(16'hFFFF, 16'h1234));
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h02, 0, 0);
        send_byte(8'h12, 0, 0);
        send_byte(8'h34, 0, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("pre_reset_in_write", {31'd0, a_we}, 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_flags", {27'd0, a_rdy, a_we, a_load, a_run, a_err}, 32'd0);
        chk("mid_rst_regs", {a_addr, a_dat}, 32'd0);
        chk("mid_rst_words", {16'd0, a_words}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'hAB;
            chk("post_rst_idle", {29'd0, a_rdy, a_load, b_load}, 32'd0);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        settle_and_drain("reset");

        // A fresh start after reset still loads correctly
        qa.push_back(wr(16'h0000, 16'h1234)); qa.push_back(wr(16'h0001, 16'hABCD)); qa.push_back(rn());
        qb.push_back(wr(16'hFFFF, 16'h1234)); qb.push_back(wr(16'h0000, 16'hABCD)); qb.push_back(rn());
        pulse_start();
        send_frame(good, 0, -1);
        settle_and_drain("after_reset");
        chk("after_reset_words", {16'd0, a_words}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
